machine_trap_ctrl: RTL and testbench
====================================

Name: machine_trap_ctrl

Overview:
- Parametrised machine-mode trap sequencer for the JAMIA core.
- Decides every cycle whether to boot, run, take a trap or return from one. Drives the PC-source mux, pipeline flush, and CSR write strobes (mepc, mcause, mstatus.MIE).
- Supports NUM_IRQ interrupt sources with programmable cause codes, six synchronous exception classes, and a configurable boot-hold length.

Parameters:
- NUM_IRQ, 3, number of interrupt sources; index 0 has the highest priority.
- CAUSE_W, 4, width of the cause code.
- IRQ_CAUSES, {4'd7,4'd3,4'd11}, packed NUM_IRQ*CAUSE_W cause codes; slice i is the cause for irq i (defaults: 0=ext 11, 1=sw 3, 2=timer 7).
- BOOT_HOLD, 2, cycles spent in RESET after rst_in deasserts; minimum 1.

Ports:
- clk_in  in  1  clock
- rst_in  in  1  reset: one clock; synchronous, active-high
- irq_in  in  NUM_IRQ  raw interrupt lines (level)
- irq_pend_in  in  NUM_IRQ  mip pending bits
- irq_en_in  in  NUM_IRQ  mie per-source enables
- mie_in  in  1  mstatus.MIE global enable
- illegal_instr_in, misaligned_instr_in, misaligned_load_in, misaligned_store_in  in  1 each  exception flags
- ecall_in, ebreak_in, mret_in  in  1 each  decoded system instructions
- pc_src_out  out  2  00 BOOT, 01 NEXT, 10 TRAP, 11 EPC
- flush_out  out  1  flush IF/ID
- instruct_inc_out  out  1  minstret increment enable
- set_epc_out, set_cause_out, mie_clear_out, mie_set_out  out  1 each  CSR write strobes
- trap_taken_out  out  1  combinational trap request
- i_or_e_out  out  1  registered: 1 = interrupt
- cause_out  out  CAUSE_W  registered cause code
- misaligned_exception_out  out  1  registered OR of the misaligned flags

Behaviour:
- States: RESET, OPERATING, TRAP_TAKEN, TRAP_RETURN. Outputs are Moore-decoded from state, except trap_taken_out.
- Reset:
  - rst_in high at an edge -> state RESET and hold counter cleared, from any state, including mid-trap.
  - RESET outputs: pc_src 00, flush 1, all strobes 0, instruct_inc 0.
  - cause_out, i_or_e_out and misaligned_exception_out clear to 0 at the same edge.
- RESET: counts BOOT_HOLD cycles, then moves to OPERATING.
- Interrupt request: irq_req[i] = irq_en_in[i] & (irq_in[i] | irq_pend_in[i]).
- Trap condition:
  - trap = (mie_in & |irq_req) | illegal | misaligned_instr | misaligned_load | misaligned_store | ecall | ebreak.
  - trap_taken_out = trap while in OPERATING; 0 in all other states.
- OPERATING:
  - Outputs: pc_src 01, flush 0, instruct_inc 1, strobes 0.
  - trap -> TRAP_TAKEN.
  - else mret_in -> TRAP_RETURN.
  - else stay. When trap and mret_in are both high, trap wins.
- Cause priority, latched at the edge entering TRAP_TAKEN:
  - First, the lowest-index active irq_req (gated by mie_in): i_or_e 1, cause = IRQ_CAUSES slice.
  - Then exceptions, i_or_e 0, in this order: illegal 2, misaligned_instr 0, ecall 11, ebreak 3, misaligned_store 6, misaligned_load 4.
  - cause_out and i_or_e_out hold their value at all other times.
- TRAP_TAKEN, exactly 1 cycle:
  - Outputs: pc_src 10, flush 1, set_epc 1, set_cause 1, mie_clear 1, instruct_inc 0.
  - Next state: OPERATING.
- TRAP_RETURN, exactly 1 cycle:
  - Outputs: pc_src 11, flush 1, mie_set 1, instruct_inc 0.
  - Next state: OPERATING.
- In TRAP_TAKEN and TRAP_RETURN, all request inputs are ignored (the pipeline is being flushed). A request still asserted on return to OPERATING traps on the following edge.
- misaligned_exception_out is registered every cycle from the OR of the three misaligned flags.
- An undefined state code recovers to OPERATING with OPERATING outputs.
- Cause codes wider than CAUSE_W are a parameter error and must fail elaboration.

Decomposition:
- Package machine_trap_pkg holds:
  - the state enum;
  - PC_BOOT/PC_NEXT/PC_TRAP/PC_EPC constants;
  - exception cause constants (2, 0, 11, 3, 6, 4).
- One sub-module, trap_cause_prio: purely combinational. Inputs are irq_req, mie_in and the exception flags; outputs are the found flag, i_or_e and cause. It is reusable by the future supervisor-mode controller.

Test Plan:
- Boot hold: rst_in 1 for 3 cycles, then 0, BOOT_HOLD=2 -> pc_src 00 / flush 1 for exactly 2 cycles after deassert, then pc_src 01, flush 0, instruct_inc 1.
- Timer interrupt: mie_in 1, irq_en 3'b100, irq_in[2] 1 for one cycle -> next cycle TRAP_TAKEN with pc_src 10, flush 1, set_epc 1, set_cause 1, mie_clear 1, i_or_e 1, cause 7; then back to pc_src 01.
- Priority: irq_in 3'b011 with all enabled, plus illegal_instr 1 -> cause 11, i_or_e 1. With mie_in 0 the same stimulus gives cause 2, i_or_e 0.
- Return: mret_in 1 alone -> one cycle of pc_src 11, flush 1, mie_set 1. With mret_in and ecall_in together -> TRAP_TAKEN, cause 11, mie_set never asserted.
- Reset mid-trap: rst_in 1 on the TRAP_TAKEN cycle -> next cycle pc_src 00, flush 1, cause 0, i_or_e 0, all strobes 0.
- Misaligned flag: misaligned_load 1 for one cycle -> misaligned_exception_out 1 for exactly the next cycle, cause 4.

Source files
------------

// File: rtl/machine_trap_pkg.sv
// Shared encodings for the machine-mode trap sequencer:
// FSM state codes, PC-source selects and exception cause codes.
package machine_trap_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_RESET       = 2'd0;
  localparam state_t ST_OPERATING   = 2'd1;
  localparam state_t ST_TRAP_TAKEN  = 2'd2;
  localparam state_t ST_TRAP_RETURN = 2'd3;

  localparam logic [1:0] PC_BOOT = 2'b00;
  localparam logic [1:0] PC_NEXT = 2'b01;
  localparam logic [1:0] PC_TRAP = 2'b10;
  localparam logic [1:0] PC_EPC  = 2'b11;

  localparam int unsigned CAUSE_ILLEGAL   = 2;
  localparam int unsigned CAUSE_MIS_INSTR = 0;
  localparam int unsigned CAUSE_ECALL     = 11;
  localparam int unsigned CAUSE_EBREAK    = 3;
  localparam int unsigned CAUSE_MIS_STORE = 6;
  localparam int unsigned CAUSE_MIS_LOAD  = 4;
  localparam int unsigned CAUSE_EXC_MAX   = 11;

  typedef struct packed {
    logic illegal;
    logic mis_instr;
    logic mis_load;
    logic mis_store;
    logic ecall;
    logic ebreak;
  } exc_t;

endpackage

// File: rtl/machine_trap_ctrl_prio.sv
// Combinational trap-cause priority picker: lowest enabled irq first,
// then synchronous exceptions in fixed architectural order.
module trap_cause_prio
  import machine_trap_pkg::*;
#(
  parameter int NUM_IRQ = 3,
  parameter int CAUSE_W = 4,
  parameter logic [NUM_IRQ*CAUSE_W-1:0] IRQ_CAUSES = '0
) (
  input  logic [NUM_IRQ-1:0] irq_req,
  input  logic               mie_in,
  input  exc_t               exc,
  output logic               found,
  output logic               i_or_e,
  output logic [CAUSE_W-1:0] cause
);

  logic [NUM_IRQ-1:0] irq_act;

  assign irq_act = irq_req & {NUM_IRQ{mie_in}};

  always_comb begin
    found  = 1'b0;
    i_or_e = 1'b0;
    cause  = '0;
    // Descending scan so the lowest index is the last writer.
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (irq_act[i]) begin
        found  = 1'b1;
        i_or_e = 1'b1;
        cause  = IRQ_CAUSES[i*CAUSE_W +: CAUSE_W];
      end
    end
    if (!found) begin
      priority case (1'b1)
        exc.illegal: begin
          found = 1'b1;
          cause = CAUSE_W'(CAUSE_ILLEGAL);
        end
        exc.mis_instr: begin
          found = 1'b1;
          cause = CAUSE_W'(CAUSE_MIS_INSTR);
        end
        exc.ecall: begin
          found = 1'b1;
          cause = CAUSE_W'(CAUSE_ECALL);
        end
        exc.ebreak: begin
          found = 1'b1;
          cause = CAUSE_W'(CAUSE_EBREAK);
        end
        exc.mis_store: begin
          found = 1'b1;
          cause = CAUSE_W'(CAUSE_MIS_STORE);
        end
        exc.mis_load: begin
          found = 1'b1;
          cause = CAUSE_W'(CAUSE_MIS_LOAD);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/machine_trap_ctrl.sv
// Machine-mode trap sequencer: boot hold, trap entry, mret return,
// PC-source select, flush and CSR write strobes.
module machine_trap_ctrl
  import machine_trap_pkg::*;
#(
  parameter int NUM_IRQ    = 3,
  parameter int CAUSE_W    = 4,
  parameter     IRQ_CAUSES = {4'd7, 4'd3, 4'd11},
  parameter int BOOT_HOLD  = 2
) (
  input  logic               clk_in,
  input  logic               rst_in,
  input  logic [NUM_IRQ-1:0] irq_in,
  input  logic [NUM_IRQ-1:0] irq_pend_in,
  input  logic [NUM_IRQ-1:0] irq_en_in,
  input  logic               mie_in,
  input  logic               illegal_instr_in,
  input  logic               misaligned_instr_in,
  input  logic               misaligned_load_in,
  input  logic               misaligned_store_in,
  input  logic               ecall_in,
  input  logic               ebreak_in,
  input  logic               mret_in,
  output logic [1:0]         pc_src_out,
  output logic               flush_out,
  output logic               instruct_inc_out,
  output logic               set_epc_out,
  output logic               set_cause_out,
  output logic               mie_clear_out,
  output logic               mie_set_out,
  output logic               trap_taken_out,
  output logic               i_or_e_out,
  output logic [CAUSE_W-1:0] cause_out,
  output logic               misaligned_exception_out
);

  if ($bits(IRQ_CAUSES) != NUM_IRQ * CAUSE_W) begin : g_bad_irq_causes
    $error("IRQ_CAUSES width must be NUM_IRQ*CAUSE_W");
  end
  if (CAUSE_W < $clog2(CAUSE_EXC_MAX + 1)) begin : g_bad_cause_w
    $error("CAUSE_W too narrow for exception cause codes");
  end
  if (BOOT_HOLD < 1) begin : g_bad_boot_hold
    $error("BOOT_HOLD must be at least 1");
  end

  localparam int CNT_W = (BOOT_HOLD > 1) ? $clog2(BOOT_HOLD) : 1;
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(BOOT_HOLD - 1);

  state_t             state;
  state_t             state_nxt;
  logic [CNT_W-1:0]   cnt;
  logic [NUM_IRQ-1:0] irq_req;
  exc_t               exc;
  logic               found;
  logic               prio_ie;
  logic [CAUSE_W-1:0] prio_cause;
  logic               mis_any;

  assign irq_req = irq_en_in & (irq_in | irq_pend_in);
  assign exc = '{
    illegal:   illegal_instr_in,
    mis_instr: misaligned_instr_in,
    mis_load:  misaligned_load_in,
    mis_store: misaligned_store_in,
    ecall:     ecall_in,
    ebreak:    ebreak_in
  };
  assign mis_any = misaligned_instr_in
                 | misaligned_load_in
                 | misaligned_store_in;

  trap_cause_prio #(
    .NUM_IRQ    (NUM_IRQ),
    .CAUSE_W    (CAUSE_W),
    .IRQ_CAUSES (IRQ_CAUSES)
  ) u_prio (
    .irq_req (irq_req),
    .mie_in  (mie_in),
    .exc     (exc),
    .found   (found),
    .i_or_e  (prio_ie),
    .cause   (prio_cause)
  );

  // Requests only count while the pipeline is running normally.
  assign trap_taken_out = found & (state == ST_OPERATING);

  always_comb begin
    state_nxt = state;
    case (state)
      ST_RESET:
        if (cnt == HOLD_LAST) state_nxt = ST_OPERATING;
      ST_OPERATING:
        if (found)        state_nxt = ST_TRAP_TAKEN;
        else if (mret_in) state_nxt = ST_TRAP_RETURN;
      ST_TRAP_TAKEN:  state_nxt = ST_OPERATING;
      ST_TRAP_RETURN: state_nxt = ST_OPERATING;
      default:        state_nxt = ST_OPERATING;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state                    <= ST_RESET;
      cnt                      <= '0;
      cause_out                <= '0;
      i_or_e_out               <= 1'b0;
      misaligned_exception_out <= 1'b0;
    end else begin
      state                    <= state_nxt;
      misaligned_exception_out <= mis_any;
      if (state == ST_RESET && cnt != HOLD_LAST)
        cnt <= cnt + CNT_W'(1);
      if (trap_taken_out) begin
        cause_out  <= prio_cause;
        i_or_e_out <= prio_ie;
      end
    end
  end

  always_comb begin
    pc_src_out       = PC_NEXT;
    flush_out        = 1'b0;
    instruct_inc_out = 1'b1;
    set_epc_out      = 1'b0;
    set_cause_out    = 1'b0;
    mie_clear_out    = 1'b0;
    mie_set_out      = 1'b0;
    case (state)
      ST_RESET: begin
        pc_src_out       = PC_BOOT;
        flush_out        = 1'b1;
        instruct_inc_out = 1'b0;
      end
      ST_TRAP_TAKEN: begin
        pc_src_out       = PC_TRAP;
        flush_out        = 1'b1;
        instruct_inc_out = 1'b0;
        set_epc_out      = 1'b1;
        set_cause_out    = 1'b1;
        mie_clear_out    = 1'b1;
      end
      ST_TRAP_RETURN: begin
        pc_src_out       = PC_EPC;
        flush_out        = 1'b1;
        instruct_inc_out = 1'b0;
        mie_set_out      = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_machine_trap_ctrl.sv
// Testbench for machine_trap_ctrl: directed vector table followed by
// randomized traffic checked against a behavioural trap model.
module tb_machine_trap_ctrl;

  localparam int BH = 2;
  localparam int M_R = 0, M_OP = 1, M_TT = 2, M_TR = 3;
  localparam logic [5:0] EX_ILL = 6'b100000;
  localparam logic [5:0] EX_MI  = 6'b010000;
  localparam logic [5:0] EX_ML  = 6'b001000;
  localparam logic [5:0] EX_MS  = 6'b000100;
  localparam logic [5:0] EX_EC  = 6'b000010;
  localparam logic [5:0] EX_EB  = 6'b000001;

  logic       clk_in = 1'b0;
  logic       rst_in;
  logic [2:0] irq_in, irq_pend_in, irq_en_in;
  logic       mie_in, mret_in;
  logic [5:0] exc;
  logic [1:0] pc_src_out;
  logic       flush_out, instruct_inc_out;
  logic       set_epc_out, set_cause_out;
  logic       mie_clear_out, mie_set_out;
  logic       trap_taken_out, i_or_e_out;
  logic [3:0] cause_out;
  logic       misaligned_exception_out;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk_in = ~clk_in;

  machine_trap_ctrl dut (
    .clk_in                   (clk_in),
    .rst_in                   (rst_in),
    .irq_in                   (irq_in),
    .irq_pend_in              (irq_pend_in),
    .irq_en_in                (irq_en_in),
    .mie_in                   (mie_in),
    .illegal_instr_in         (exc[5]),
    .misaligned_instr_in      (exc[4]),
    .misaligned_load_in       (exc[3]),
    .misaligned_store_in      (exc[2]),
    .ecall_in                 (exc[1]),
    .ebreak_in                (exc[0]),
    .mret_in                  (mret_in),
    .pc_src_out               (pc_src_out),
    .flush_out                (flush_out),
    .instruct_inc_out         (instruct_inc_out),
    .set_epc_out              (set_epc_out),
    .set_cause_out            (set_cause_out),
    .mie_clear_out            (mie_clear_out),
    .mie_set_out              (mie_set_out),
    .trap_taken_out           (trap_taken_out),
    .i_or_e_out               (i_or_e_out),
    .cause_out                (cause_out),
    .misaligned_exception_out (misaligned_exception_out)
  );

  typedef struct {
    logic       rst;
    logic [2:0] irq;
    logic [2:0] pend;
    logic [2:0] en;
    logic       mie;
    logic [5:0] exc;
    logic       mret;
    int         mode;
    logic       ie;
    logic [3:0] cause;
    logic       mis;
    logic       tt;
  } vec_t;

  function automatic vec_t mk(
    logic rst, logic [2:0] irq, logic [2:0] pend,
    logic [2:0] en, logic mie, logic [5:0] ex,
    logic mret, int mode, logic ie,
    logic [3:0] cause, logic mis, logic tt);
    vec_t v;
    v.rst = rst; v.irq = irq; v.pend = pend;
    v.en = en; v.mie = mie; v.exc = ex;
    v.mret = mret; v.mode = mode; v.ie = ie;
    v.cause = cause; v.mis = mis; v.tt = tt;
    return v;
  endfunction

  // {pc_src, flush, inc, epc, cause_we, mie_clr, mie_set, ie, cause, mis}
  function automatic logic [13:0] exp_out(
    int mode, logic ie, logic [3:0] cause, logic mis);
    logic [7:0] m;
    case (mode)
      M_R:     m = 8'b00_1_0_0000;
      M_TT:    m = 8'b10_1_0_1110;
      M_TR:    m = 8'b11_1_0_0001;
      default: m = 8'b01_0_1_0000;
    endcase
    return {m, ie, cause, mis};
  endfunction

  function automatic logic [13:0] act_out();
    return {pc_src_out, flush_out, instruct_inc_out,
            set_epc_out, set_cause_out, mie_clear_out,
            mie_set_out, i_or_e_out, cause_out,
            misaligned_exception_out};
  endfunction

  task automatic check(input string name, input int idx,
                       input logic [13:0] got,
                       input logic [13:0] want);
    n_chk++;
    if (got === want) n_pass++;
    else $display("FAIL %s #%0d: got %b want %b",
                  name, idx, got, want);
  endtask

  task automatic drive(input logic rst, input logic [2:0] irq,
                       input logic [2:0] pend, input logic [2:0] en,
                       input logic mie, input logic [5:0] ex,
                       input logic mret);
    rst_in = rst; irq_in = irq; irq_pend_in = pend;
    irq_en_in = en; mie_in = mie; exc = ex; mret_in = mret;
  endtask

  // Reference model state
  int         boot_left;
  int         kind;  // 0 running, 1 trap entry, 2 mret
  logic       m_ie, m_mis;
  logic [3:0] m_cause;

  task automatic decide(output logic f, output logic ie,
                        output logic [3:0] c);
    int icode[3] = '{11, 3, 7};
    int ord[6]   = '{5, 4, 1, 0, 2, 3};
    int ecode[6] = '{2, 0, 11, 3, 6, 4};
    f = 0; ie = 0; c = 0;
    for (int i = 0; i < 3; i++)
      if (!f && mie_in && irq_en_in[i]
          && (irq_in[i] || irq_pend_in[i])) begin
        f = 1; ie = 1; c = 4'(icode[i]);
      end
    for (int k = 0; k < 6; k++)
      if (!f && exc[ord[k]]) begin
        f = 1; c = 4'(ecode[k]);
      end
  endtask

  function automatic int m_mode();
    if (boot_left > 0) return M_R;
    if (kind == 1) return M_TT;
    if (kind == 2) return M_TR;
    return M_OP;
  endfunction

  vec_t tbl[31];

  initial begin
    logic f, ie;
    logic [3:0] c;

    tbl[0]  = mk(1,0,0,0,0,0,0,M_R,0,0,0,0);
    tbl[1]  = mk(1,0,0,0,0,0,0,M_R,0,0,0,0);
    tbl[2]  = mk(0,0,0,0,0,0,0,M_R,0,0,0,0);
    tbl[3]  = mk(0,0,0,0,0,0,0,M_OP,0,0,0,0);
    tbl[4]  = mk(0,3'b100,0,3'b100,1,0,0,M_TT,1,7,0,1);
    tbl[5]  = mk(0,0,0,0,0,0,0,M_OP,1,7,0,0);
    tbl[6]  = mk(0,3'b011,0,3'b111,1,EX_ILL,0,M_TT,1,11,0,1);
    tbl[7]  = mk(0,0,0,0,0,0,0,M_OP,1,11,0,0);
    tbl[8]  = mk(0,3'b011,0,3'b111,0,EX_ILL,0,M_TT,0,2,0,1);
    tbl[9]  = mk(0,0,0,0,0,0,0,M_OP,0,2,0,0);
    tbl[10] = mk(0,0,0,0,0,0,1,M_TR,0,2,0,0);
    tbl[11] = mk(0,0,0,0,0,0,0,M_OP,0,2,0,0);
    tbl[12] = mk(0,0,0,0,0,EX_EC,1,M_TT,0,11,0,1);
    tbl[13] = mk(0,0,0,0,0,0,0,M_OP,0,11,0,0);
    tbl[14] = mk(0,0,0,0,0,EX_EC,0,M_TT,0,11,0,1);
    tbl[15] = mk(1,0,0,0,0,0,0,M_R,0,0,0,0);
    tbl[16] = mk(0,0,0,0,0,0,0,M_R,0,0,0,0);
    tbl[17] = mk(0,0,0,0,0,0,0,M_OP,0,0,0,0);
    tbl[18] = mk(0,0,0,0,0,EX_ML,0,M_TT,0,4,1,1);
    tbl[19] = mk(0,0,0,0,0,0,0,M_OP,0,4,0,0);
    tbl[20] = mk(0,0,0,0,0,EX_MS,0,M_TT,0,6,1,1);
    tbl[21] = mk(0,0,0,0,0,EX_MS,0,M_OP,0,6,1,0);
    tbl[22] = mk(0,0,0,0,0,EX_MS,0,M_TT,0,6,1,1);
    tbl[23] = mk(0,0,0,0,0,0,0,M_OP,0,6,0,0);
    tbl[24] = mk(0,0,3'b010,3'b010,1,0,0,M_TT,1,3,0,1);
    tbl[25] = mk(0,0,0,0,0,0,0,M_OP,1,3,0,0);
    tbl[26] = mk(0,3'b111,0,0,1,0,0,M_OP,1,3,0,0);
    tbl[27] = mk(0,0,0,0,0,EX_MI|EX_EB,0,M_TT,0,0,1,1);
    tbl[28] = mk(0,0,0,0,0,0,0,M_OP,0,0,0,0);
    tbl[29] = mk(0,0,0,0,0,EX_EB,0,M_TT,0,3,0,1);
    tbl[30] = mk(0,0,0,0,0,0,0,M_OP,0,3,0,0);

    drive(1, 0, 0, 0, 0, 0, 0);
    @(posedge clk_in); #1;

    foreach (tbl[i]) begin
      drive(tbl[i].rst, tbl[i].irq, tbl[i].pend, tbl[i].en,
            tbl[i].mie, tbl[i].exc, tbl[i].mret);
      #1;
      check("vec_trap_taken", i, {13'b0, trap_taken_out},
            {13'b0, tbl[i].tt});
      @(posedge clk_in); #1;
      check("vec_outputs", i, act_out(),
            exp_out(tbl[i].mode, tbl[i].ie,
                    tbl[i].cause, tbl[i].mis));
    end

    boot_left = 0; kind = 0;
    m_ie = 0; m_mis = 0; m_cause = 0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      drive((cyc == 0) || ($urandom % 50 == 0),
            ($urandom % 4 == 0) ? 3'($urandom) : 3'b0,
            ($urandom % 5 == 0) ? 3'($urandom) : 3'b0,
            3'($urandom),
            1'($urandom),
            {($urandom % 14 == 0), ($urandom % 14 == 0),
             ($urandom % 14 == 0), ($urandom % 14 == 0),
             ($urandom % 14 == 0), ($urandom % 14 == 0)},
            ($urandom % 5 == 0));
      #1;
      decide(f, ie, c);
      if (cyc > 0)
        check("rand_trap_taken", cyc, {13'b0, trap_taken_out},
              {13'b0, f && boot_left == 0 && kind == 0});
      if (rst_in) begin
        boot_left = BH; kind = 0;
        m_ie = 0; m_cause = 0; m_mis = 0;
      end else begin
        m_mis = exc[4] | exc[3] | exc[2];
        if (boot_left > 0) boot_left--;
        else if (kind != 0) kind = 0;
        else if (f) begin
          kind = 1; m_ie = ie; m_cause = c;
        end else if (mret_in) kind = 2;
      end
      @(posedge clk_in); #1;
      check("rand_outputs", cyc, act_out(),
            exp_out(m_mode(), m_ie, m_cause, m_mis));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
